biphase_rx_autobaud: RTL and testbench
======================================

# biphase_rx_autobaud

Biphase (FM1 / biphase-mark) to NRZ decoder that learns the bit period from the incoming line instead of using a fixed compile-time pulse length. It hunts for a run of consistent long pulses (idle marking), locks to the measured period, then decodes within a tolerance window. It drops lock on repeated errors or a dead line. It sits between the console line input pin and the downstream UART/frame logic, and is the parametrised successor of the fixed-rate biphase decoder.

## Interface
- CNT_W, 12: pulse counter width; max measurable pulse is 2^CNT_W-1 clocks.
- IGNORE_PULSE, 25: pulses shorter than this, in clocks, are glitches.
- MIN_LONG, 64: shortest long pulse accepted for training, in clocks.
- LOCK_PULSES, 8: consecutive consistent long pulses required to lock.
- TOL_SHIFT, 2: tolerance = reference >> TOL_SHIFT.
- ERR_LIMIT, 4: consecutive framing errors that drop lock.
- INVERT, 0: 0 = long pulse decodes as 1; 1 = long pulse decodes as 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- biphase_in_raw  in  1  asynchronous line input
- nrz_out  out  1  last decoded bit
- clock_out  out  1  toggles once per decoded bit
- data_received  out  1  one-clk pulse per decoded bit
- framing_error  out  1  one-clk pulse
- glitch_ignored  out  1  one-clk pulse
- locked  out  1  high while in LOCKED
- lock_lost  out  1  one-clk pulse on LOCKED→HUNT
- long_len  out  CNT_W  learned long-pulse length T; 0 while unlocked
- counter_overflow  out  1  counter saturated since last transition

## Operation
- Two-flop synchronizer, then a last-value flop. A transition is biphase_last != biphase_in.
- The counter resets to 1 on a transition and increments otherwise. It saturates at all-ones, which sets counter_overflow; the next transition clears counter_overflow. M is the counter value at a transition, equal to the clocks since the previous transition.
- Every transition first checks for a glitch. If M < IGNORE_PULSE, glitch_ignored pulses, and no other state changes except the counter reset.
- HUNT state:
  - M >= MIN_LONG and (run_count == 0 or |M - run_ref| > run_ref >> TOL_SHIFT): set run_ref = M and run_count = 1.
  - M within tolerance of run_ref: run_count++.
  - M < MIN_LONG and not a glitch: run_count = 0.
  - When run_count reaches LOCK_PULSES, move to LOCKED with T = run_ref, S = T >> 1, short_seen = 0, err_count = 0.
  - No data or framing pulses are produced in HUNT.
- LOCKED state: tolT = T >> TOL_SHIFT, tolS = S >> TOL_SHIFT. Check in this order:
  - Short, |M - S| <= tolS:
    - If short_seen is 0, set short_seen.
    - Otherwise, decode bit 0 (1 if INVERT): pulse data_received, toggle clock_out, clear short_seen.
  - Long, |M - T| <= tolT: decode bit 1 (0 if INVERT), pulse data_received, toggle clock_out. If short_seen was set, also pulse framing_error. Clear short_seen.
  - Otherwise: pulse framing_error and clear short_seen.
  - Any error increments err_count. Any decoded bit with no error clears err_count.
  - When err_count reaches ERR_LIMIT: go to HUNT, pulse lock_lost, clear run_count.
  - Counter saturation while LOCKED (dead line) forces HUNT and pulses lock_lost immediately, with no framing_error.
- Tolerance arithmetic is unsigned, CNT_W+1 bits wide, with no wrap. Comparisons are inclusive.
- Reset mid-operation: go to HUNT. All outputs return to their reset values on the next clock. Decoding restarts from scratch.

## Timing
- Reset values: nrz_out=0, clock_out=0, data_received=0, framing_error=0, glitch_ignored=0, locked=0, lock_lost=0, long_len=0, counter_overflow=0. Internally, counter=1, run_count=0, short_seen=0, err_count=0.
- Latency: a raw edge sampled at clock edge k makes the flag outputs high after edge k+2. Flags stay high for exactly one clock.
- nrz_out and clock_out update on the same edge as data_received and then hold.
- locked rises and long_len loads on the same edge as the LOCK_PULSES-th qualifying transition.
- locked falls on the same edge that lock_lost pulses.
- Back-to-back transitions on consecutive clocks are each processed, giving M=1 (glitch).

## Test plan
- Lock: 50 MHz clock, eight pulses of 600 clks → locked=1 on the 8th transition, long_len=600, and no data_received during training.
- Decode: after lock, pulses 300,300,600,290,310 → bits 0,1,0. clock_out toggles 3 times. No framing_error.
- Tolerance: after lock, pulses 740 (1), 460 (1), 400 (framing_error), 380 (framing_error; short window is 225–375) → err_count=2, still locked.
- Glitch: after lock, pulse 300 then a 10-clk runt → glitch_ignored pulses. The runt is dropped and short_seen stays set. The following short-length pulse then decodes 0 with no framing_error.
- Lock loss: after lock, four 400-clk pulses → four framing_error pulses. On the 4th, lock_lost=1, locked=0, long_len=0. Separately, a line held static for 4095 clks while locked → lock_lost with no framing_error, and counter_overflow=1.
- Reset: assert rst for 1 clk mid-decode → all outputs at reset values, and exactly LOCK_PULSES pulses are required to relock. Repeat with INVERT=1 → the decode test yields bits 1,0,1.

Source files
------------

// File: rtl/biphase_rx_autobaud.sv
// Biphase-mark (FM1) to NRZ decoder with automatic bit-period learning.
//
// The line is synchronised and every level change is measured in clocks (M).
// In HUNT the decoder looks for LOCK_PULSES consecutive long pulses that agree
// within tolerance and adopts their length as the bit period T. In LOCKED it
// decodes a full-period pulse as one bit value and a pair of half-period
// pulses as the other. Lock is dropped after ERR_LIMIT consecutive framing
// errors or when the pulse counter saturates (dead line).
//
// Ports:
//   clk              system clock
//   rst              synchronous active-high reset
//   biphase_in_raw   asynchronous biphase line input
//   nrz_out          last decoded bit
//   clock_out        toggles once per decoded bit
//   data_received    one-clock pulse per decoded bit
//   framing_error    one-clock pulse per framing error
//   glitch_ignored   one-clock pulse per rejected runt pulse
//   locked           high while locked to a bit period
//   lock_lost        one-clock pulse on LOCKED -> HUNT
//   long_len         learned long-pulse length T, 0 while unlocked
//   counter_overflow pulse counter saturated since the last transition
module biphase_rx_autobaud #(
  parameter int unsigned CNT_W        = 12,
  parameter int unsigned IGNORE_PULSE = 25,
  parameter int unsigned MIN_LONG     = 64,
  parameter int unsigned LOCK_PULSES  = 8,
  parameter int unsigned TOL_SHIFT    = 2,
  parameter int unsigned ERR_LIMIT    = 4,
  parameter int unsigned INVERT       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             biphase_in_raw,
  output logic             nrz_out,
  output logic             clock_out,
  output logic             data_received,
  output logic             framing_error,
  output logic             glitch_ignored,
  output logic             locked,
  output logic             lock_lost,
  output logic [CNT_W-1:0] long_len,
  output logic             counter_overflow
);

  localparam int unsigned      RC_W       = $clog2(LOCK_PULSES + 1);
  localparam int unsigned      EC_W       = $clog2(ERR_LIMIT + 1);
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntNearMax = CntMax - 1'b1;
  localparam logic [CNT_W-1:0] IgnoreLen  = CNT_W'(IGNORE_PULSE);
  localparam logic [CNT_W-1:0] MinLong    = CNT_W'(MIN_LONG);
  localparam logic [RC_W-1:0]  LockCnt    = RC_W'(LOCK_PULSES);
  localparam logic [EC_W-1:0]  ErrLim     = EC_W'(ERR_LIMIT);
  localparam logic             Inv        = (INVERT != 0);

  typedef enum logic {StHunt, StLocked} state_e;

  // Unsigned distance, one bit wider than the counter so it never wraps.
  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W:0] a,
                                              input logic [CNT_W:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic             sync1_q, sync2_q, last_q;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic             ovf_q, ovf_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] run_ref_q, run_ref_d;
  logic [RC_W-1:0]  run_count_q, run_count_d;
  logic [CNT_W-1:0] long_len_q, long_len_d;
  logic             short_seen_q, short_seen_d;
  logic [EC_W-1:0]  err_count_q, err_count_d;
  logic             nrz_q, nrz_d;
  logic             clock_q, clock_d;
  logic             data_q, data_d;
  logic             ferr_q, ferr_d;
  logic             glitch_q, glitch_d;
  logic             lost_q, lost_d;

  logic             transition;
  logic             dead_line;
  logic [CNT_W:0]   m_ext, ref_ext, t_ext, s_ext;
  logic [CNT_W:0]   diff_run, diff_t, diff_s;
  logic [CNT_W:0]   tol_run, tol_t, tol_s;
  logic             err_hit, clean_bit, drop;

  assign transition = last_q ^ sync2_q;
  // Fires once, on the clock the counter steps onto all-ones.
  assign dead_line  = !transition && (counter_q == CntNearMax);

  assign m_ext    = {1'b0, counter_q};
  assign ref_ext  = {1'b0, run_ref_q};
  assign t_ext    = {1'b0, long_len_q};
  assign s_ext    = t_ext >> 1;
  assign tol_run  = ref_ext >> TOL_SHIFT;
  assign tol_t    = t_ext >> TOL_SHIFT;
  assign tol_s    = s_ext >> TOL_SHIFT;
  assign diff_run = abs_diff(m_ext, ref_ext);
  assign diff_t   = abs_diff(m_ext, t_ext);
  assign diff_s   = abs_diff(m_ext, s_ext);

  // Pulse-length counter: restarts at 1 on a transition, saturates at all-ones.
  always_comb begin
    counter_d = counter_q;
    ovf_d     = ovf_q;
    if (transition) begin
      counter_d = {{(CNT_W-1){1'b0}}, 1'b1};
      ovf_d     = 1'b0;
    end else if (counter_q != CntMax) begin
      counter_d = counter_q + 1'b1;
      if (dead_line) ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    run_ref_d    = run_ref_q;
    run_count_d  = run_count_q;
    long_len_d   = long_len_q;
    short_seen_d = short_seen_q;
    err_count_d  = err_count_q;
    nrz_d        = nrz_q;
    clock_d      = clock_q;
    data_d       = 1'b0;
    ferr_d       = 1'b0;
    glitch_d     = 1'b0;
    lost_d       = 1'b0;
    err_hit      = 1'b0;
    clean_bit    = 1'b0;
    drop         = 1'b0;

    if (transition) begin
      if (counter_q < IgnoreLen) begin
        glitch_d = 1'b1;
      end else if (state_q == StHunt) begin
        if (counter_q < MinLong) begin
          run_count_d = '0;
        end else if ((run_count_q == '0) || (diff_run > tol_run)) begin
          // Start a new training run around this pulse.
          run_ref_d   = counter_q;
          run_count_d = {{(RC_W-1){1'b0}}, 1'b1};
        end else begin
          run_count_d = run_count_q + 1'b1;
        end
        if (run_count_d == LockCnt) begin
          state_d      = StLocked;
          long_len_d   = run_ref_d;
          short_seen_d = 1'b0;
          err_count_d  = '0;
        end
      end else begin
        if (diff_s <= tol_s) begin
          if (!short_seen_q) begin
            short_seen_d = 1'b1;
          end else begin
            data_d       = 1'b1;
            clock_d      = ~clock_q;
            nrz_d        = Inv;
            short_seen_d = 1'b0;
            clean_bit    = 1'b1;
          end
        end else if (diff_t <= tol_t) begin
          data_d       = 1'b1;
          clock_d      = ~clock_q;
          nrz_d        = ~Inv;
          short_seen_d = 1'b0;
          // A long pulse after an unpaired half-period still decodes, but flags.
          if (short_seen_q) begin
            ferr_d  = 1'b1;
            err_hit = 1'b1;
          end else begin
            clean_bit = 1'b1;
          end
        end else begin
          ferr_d       = 1'b1;
          err_hit      = 1'b1;
          short_seen_d = 1'b0;
        end

        if (err_hit) begin
          if (err_count_q + 1'b1 == ErrLim) begin
            drop = 1'b1;
          end else begin
            err_count_d = err_count_q + 1'b1;
          end
        end else if (clean_bit) begin
          err_count_d = '0;
        end
      end
    end else if (dead_line && (state_q == StLocked)) begin
      drop = 1'b1;
    end

    if (drop) begin
      state_d      = StHunt;
      lost_d       = 1'b1;
      long_len_d   = '0;
      run_count_d  = '0;
      err_count_d  = '0;
      short_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      last_q       <= 1'b0;
      counter_q    <= {{(CNT_W-1){1'b0}}, 1'b1};
      ovf_q        <= 1'b0;
      state_q      <= StHunt;
      run_ref_q    <= '0;
      run_count_q  <= '0;
      long_len_q   <= '0;
      short_seen_q <= 1'b0;
      err_count_q  <= '0;
      nrz_q        <= 1'b0;
      clock_q      <= 1'b0;
      data_q       <= 1'b0;
      ferr_q       <= 1'b0;
      glitch_q     <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      sync1_q      <= biphase_in_raw;
      sync2_q      <= sync1_q;
      last_q       <= sync2_q;
      counter_q    <= counter_d;
      ovf_q        <= ovf_d;
      state_q      <= state_d;
      run_ref_q    <= run_ref_d;
      run_count_q  <= run_count_d;
      long_len_q   <= long_len_d;
      short_seen_q <= short_seen_d;
      err_count_q  <= err_count_d;
      nrz_q        <= nrz_d;
      clock_q      <= clock_d;
      data_q       <= data_d;
      ferr_q       <= ferr_d;
      glitch_q     <= glitch_d;
      lost_q       <= lost_d;
    end
  end

  assign nrz_out          = nrz_q;
  assign clock_out        = clock_q;
  assign data_received    = data_q;
  assign framing_error    = ferr_q;
  assign glitch_ignored   = glitch_q;
  assign locked           = (state_q == StLocked);
  assign lock_lost        = lost_q;
  assign long_len         = long_len_q;
  assign counter_overflow = ovf_q;

endmodule

// File: tb/tb_biphase_rx_autobaud.sv
// Self-checking bench for biphase_rx_autobaud: two instances (INVERT=0/1) share
// one line; a pulse-level reference model predicts flags, levels and counts.
module tb_biphase_rx_autobaud;

  localparam int MAXC   = 4095;
  localparam int IGN    = 25;
  localparam int MINL   = 64;
  localparam int LOCKP  = 8;
  localparam int ERRL   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line = 1'b0;

  logic        nrz_a, clko_a, dr_a, fe_a, gl_a, lk_a, ll_a, ov_a;
  logic [11:0] len_a;
  logic        nrz_b, clko_b, dr_b, fe_b, gl_b, lk_b, ll_b, ov_b;
  logic [11:0] len_b;

  always #10 clk = ~clk;

  biphase_rx_autobaud #(.INVERT(0)) dut_a (
    .clk(clk), .rst(rst), .biphase_in_raw(line), .nrz_out(nrz_a), .clock_out(clko_a),
    .data_received(dr_a), .framing_error(fe_a), .glitch_ignored(gl_a), .locked(lk_a),
    .lock_lost(ll_a), .long_len(len_a), .counter_overflow(ov_a)
  );

  biphase_rx_autobaud #(.INVERT(1)) dut_b (
    .clk(clk), .rst(rst), .biphase_in_raw(line), .nrz_out(nrz_b), .clock_out(clko_b),
    .data_received(dr_b), .framing_error(fe_b), .glitch_ignored(gl_b), .locked(lk_b),
    .lock_lost(ll_b), .long_len(len_b), .counter_overflow(ov_b)
  );

  // Pulse counters sampled mid-cycle; a flag held two clocks counts twice.
  int c_dr = 0, c_fe = 0, c_gl = 0, c_ll = 0, c_dr_b = 0;
  always @(negedge clk) begin
    if (dr_a === 1'b1) c_dr <= c_dr + 1;
    if (fe_a === 1'b1) c_fe <= c_fe + 1;
    if (gl_a === 1'b1) c_gl <= c_gl + 1;
    if (ll_a === 1'b1) c_ll <= c_ll + 1;
    if (dr_b === 1'b1) c_dr_b <= c_dr_b + 1;
  end

  // Reference model state
  logic m_locked, m_short, m_nrz, m_nrzb, m_clk;
  int   m_ref, m_rc, m_T, m_err;
  int   e_dr = 0, e_fe = 0, e_gl = 0, e_ll = 0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_short = 0; m_nrz = 0; m_nrzb = 0; m_clk = 0;
    m_ref = 0; m_rc = 0; m_T = 0; m_err = 0;
  endtask

  task automatic model_drop(inout logic [3:0] fl);
    m_locked = 0; m_T = 0; m_rc = 0; m_err = 0; m_short = 0;
    e_ll++;
    fl[3] = 1'b1;
  endtask

  task automatic model_bit(input logic b, inout logic [3:0] fl);
    e_dr++;
    m_clk = ~m_clk;
    m_nrz = b;
    m_nrzb = ~b;
    fl[0] = 1'b1;
  endtask

  // fl = {lock_lost, glitch, framing_error, data} expected for this transition
  task automatic model_trans(input int m, output logic [3:0] fl);
    int  s, tol_t, tol_s;
    bit  bad, good;
    fl = 4'b0;
    if (m < IGN) begin
      fl[2] = 1'b1;
      e_gl++;
    end else if (!m_locked) begin
      if (m < MINL) m_rc = 0;
      else if (m_rc == 0 || absd(m, m_ref) > m_ref / 4) begin
        m_ref = m;
        m_rc  = 1;
      end else m_rc++;
      if (m_rc == LOCKP) begin
        m_locked = 1; m_T = m_ref; m_short = 0; m_err = 0;
      end
    end else begin
      s = m_T / 2; tol_t = m_T / 4; tol_s = s / 4;
      bad = 0; good = 0;
      if (absd(m, s) <= tol_s) begin
        if (m_short) begin
          model_bit(1'b0, fl); good = 1; m_short = 0;
        end else m_short = 1;
      end else if (absd(m, m_T) <= tol_t) begin
        model_bit(1'b1, fl);
        if (m_short) bad = 1; else good = 1;
        m_short = 0;
      end else begin
        bad = 1; m_short = 0;
      end
      if (bad) begin
        fl[1] = 1'b1;
        e_fe++;
        m_err++;
        if (m_err == ERRL) model_drop(fl);
      end else if (good) m_err = 0;
    end
  endtask

  // Line holds for p clocks, then toggles; the transition is then checked.
  task automatic send(input int p);
    logic [3:0] fl;
    logic       old_locked;
    int         m;
    repeat (p - 4) @(posedge clk);
    #1;
    chk("ovf_before_edge", ov_a, (p > 4100));
    if (p >= MAXC && m_locked) begin
      fl = 4'b0;
      model_drop(fl);
    end
    old_locked = m_locked;
    line = ~line;
    m = (p > MAXC) ? MAXC : p;
    model_trans(m, fl);
    @(posedge clk); @(posedge clk); #1;
    chk("flags_early", {ll_a, gl_a, fe_a, dr_a}, 4'b0);
    chk("locked_early", lk_a, old_locked);
    @(posedge clk); #1;
    chk("flags_a", {ll_a, gl_a, fe_a, dr_a}, fl);
    chk("flags_b", {ll_b, gl_b, fe_b, dr_b}, fl);
    chk("levels", {lk_a, nrz_a, clko_a, lk_b, nrz_b, clko_b},
        {m_locked, m_nrz, m_clk, m_locked, m_nrzb, m_clk});
    chk("long_len", {len_a, len_b}, {12'(m_T), 12'(m_T)});
    @(posedge clk); #1;
    chk("counts", {16'(c_dr), 16'(c_fe), 16'(c_gl), 16'(c_ll)},
        {16'(e_dr), 16'(e_fe), 16'(e_gl), 16'(e_ll)});
    chk("count_b", c_dr_b, e_dr);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    line = 1'b0;
    rst  = 1'b1;
    @(posedge clk); #1;
    rst  = 1'b0;
    model_reset();
    chk("reset_a", {nrz_a, clko_a, dr_a, fe_a, gl_a, lk_a, ll_a, len_a, ov_a}, '0);
    chk("reset_b", {nrz_b, clko_b, dr_b, fe_b, gl_b, lk_b, ll_b, len_b, ov_b}, '0);
  endtask

  // A short non-glitch pulse first so training starts from a known point.
  task automatic train(input int t);
    send(45);
    for (int i = 0; i < LOCKP; i++) send(t);
  endtask

  initial begin
    int fe0, t, s, k, p, w;
    model_reset();
    do_reset();

    // Lock onto 600-clock pulses
    train(600);
    chk("lock_locked", lk_a, 1'b1);
    chk("lock_len", len_a, 12'd600);
    chk("lock_no_data", c_dr, 0);

    // Decode 0,1,0 (INVERT instance sees 1,0,1)
    send(300); send(300);
    chk("dec_bit0_a", nrz_a, 1'b0);
    chk("dec_bit0_b", nrz_b, 1'b1);
    send(600);
    chk("dec_bit1_a", nrz_a, 1'b1);
    chk("dec_bit1_b", nrz_b, 1'b0);
    send(290); send(310);
    chk("dec_bits", c_dr, 3);
    chk("dec_clk", clko_a, 1'b1);
    chk("dec_no_ferr", c_fe, 0);

    // Tolerance window edges
    send(740); send(460); send(400); send(380);
    chk("tol_ferr", c_fe, 2);
    chk("tol_still_locked", lk_a, 1'b1);

    // Runt inside a short pair is dropped
    send(300); send(10); send(300);
    chk("glitch_seen", c_gl, 1);
    chk("glitch_bit", nrz_a, 1'b0);
    chk("glitch_no_ferr", c_fe, 2);

    // Four consecutive framing errors drop lock
    for (int i = 0; i < 4; i++) send(400);
    chk("loss_pulse", c_ll, 1);
    chk("loss_state", {lk_a, len_a}, 13'd0);

    // Dead line while locked
    train(600);
    fe0 = c_fe;
    send(5000);
    chk("dead_loss", c_ll, 2);
    chk("dead_no_ferr", c_fe, fe0);

    // Reset mid-decode, then relock from scratch
    train(600);
    send(300);
    do_reset();
    train(600);
    chk("relock", lk_a, 1'b1);

    // Randomised rates and pulse mixes
    for (int it = 0; it < 3; it++) begin
      do_reset();
      t = int'($urandom_range(150, 450));
      s = t / 2;
      train(t);
      for (int j = 0; j < 25; j++) begin
        k = int'($urandom_range(0, 4));
        case (k)
          0, 4: begin w = s / 4 + 3; p = s + int'($urandom_range(0, 2 * w)) - w; end
          1: begin w = t / 4 + 3; p = t + int'($urandom_range(0, 2 * w)) - w; end
          2: p = int'($urandom_range(5, 24));
          default: p = int'($urandom_range(25, 2 * t + 100));
        endcase
        if (p < 5) p = 5;
        send(p);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
